// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix-multiply array.
// Holds the default operand width and the per-lane wavefront depth.
package systolic_pkg;

    localparam int DATA_WIDTH = 32;

    // Number of delay stages in lane i. The array top calls this too,
    // so the operand skew and the PE wavefront always agree.
    function automatic int lane_depth(input int i,
                                      input int base,
                                      input int skew);
        return base + i * skew;
    endfunction

endpackage

// File: rtl/delay_line.sv
// Single-lane delay chain of DEPTH stages. Each stage holds a data
// word and a valid bit.
// Ports: clk, rst (sync, active-low), en (advance), flush (clear
// valids), in_valid/in_data (stage 0 input), out_valid/out_data
// (last stage), any_valid (OR of every valid bit in the chain).
module delay_line
    import systolic_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             any_valid
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
            valid_q <= '0;
        end else begin
            // Data moves with en only; flush never touches data.
            if (en) begin
                data_q[0] <= in_data;
                for (int k = 1; k < DEPTH; k++) begin
                    data_q[k] <= data_q[k-1];
                end
            end
            // Flush wins over en for the valid bits.
            if (flush) begin
                valid_q <= '0;
            end else if (en) begin
                valid_q[0] <= in_valid;
                for (int k = 1; k < DEPTH; k++) begin
                    valid_q[k] <= valid_q[k-1];
                end
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign any_valid = |valid_q;

endmodule

// File: rtl/skew_delay_bank.sv
// Multi-lane skewing delay bank feeding one edge of the systolic array.
// Lane i delays data/valid by BASE_DELAY + i*SKEW enabled cycles.
// Ports: clk, rst (sync, active-low), en (global advance), flush
// (clear all valids), in_valid/in_data (lane i at [i*WIDTH +: WIDTH]),
// out_valid/out_data (registered, same packing), drained (no valid
// held anywhere in the bank).
module skew_delay_bank
    import systolic_pkg::*;
#(
    parameter int WIDTH      = DATA_WIDTH,
    parameter int LANES      = 4,
    parameter int BASE_DELAY = 1,
    parameter int SKEW       = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   flush,
    input  logic [LANES-1:0]       in_valid,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic [LANES-1:0]       out_valid,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic                   drained
);

    logic [LANES-1:0] any_valid;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        delay_line #(
            .WIDTH (WIDTH),
            .DEPTH (lane_depth(i, BASE_DELAY, SKEW))
        ) u_line (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .flush     (flush),
            .in_valid  (in_valid[i]),
            .in_data   (in_data[i*WIDTH +: WIDTH]),
            .out_valid (out_valid[i]),
            .out_data  (out_data[i*WIDTH +: WIDTH]),
            .any_valid (any_valid[i])
        );
    end

    assign drained = ~|any_valid;

endmodule

// File: tb/tb_skew_delay_bank.sv
// Directed bench for skew_delay_bank: default bank plus two
// parameter-sweep instances (1 lane deep, 8 lanes wide skew).
module tb_skew_delay_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst   = 1'b0;
    logic en    = 1'b1;
    logic flush = 1'b0;

    logic [3:0]   in_valid  = '0;
    logic [127:0] in_data   = '0;
    logic [3:0]   out_valid;
    logic [127:0] out_data;
    logic         drained;

    logic [0:0]   in_valid1 = '0;
    logic [31:0]  in_data1  = '0;
    logic [0:0]   out_valid1;
    logic [31:0]  out_data1;
    logic         drained1;

    logic [7:0]   in_valid8 = '0;
    logic [255:0] in_data8  = '0;
    logic [7:0]   out_valid8;
    logic [255:0] out_data8;
    logic         drained8;

    int passed = 0;
    int total  = 0;

    skew_delay_bank #(
        .WIDTH(32), .LANES(4), .BASE_DELAY(1), .SKEW(1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data),
        .drained(drained)
    );

    skew_delay_bank #(
        .WIDTH(32), .LANES(1), .BASE_DELAY(3), .SKEW(0)
    ) dut1 (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(in_valid1), .in_data(in_data1),
        .out_valid(out_valid1), .out_data(out_data1),
        .drained(drained1)
    );

    skew_delay_bank #(
        .WIDTH(32), .LANES(8), .BASE_DELAY(1), .SKEW(2)
    ) dut8 (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(in_valid8), .in_data(in_data8),
        .out_valid(out_valid8), .out_data(out_data8),
        .drained(drained8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_valid = 4'($urandom);
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        total++;
        if (out_valid !== 4'b0)
            $display("FAIL reset_valid: got %b want 0000", out_valid);
        else passed++;
        total++;
        if (out_data !== 128'd0)
            $display("FAIL reset_data: got %h want 0", out_data);
        else passed++;
        total++;
        if (drained !== 1'b1)
            $display("FAIL reset_drained: got %b want 1", drained);
        else passed++;
        in_valid = '0;
        in_data  = '0;
        rst = 1'b1;
        step();
    endtask

    task automatic test_skew();
        logic [3:0] ev;
        in_valid = 4'hF;
        for (int i = 0; i < 4; i++)
            in_data[i*32 +: 32] = 32'hA0 + i;
        step();
        in_valid = '0;
        in_data  = '0;
        for (int k = 0; k < 4; k++) begin
            ev = 4'b0001 << k;
            total++;
            if (out_valid !== ev)
                $display("FAIL skew_valid_e%0d: got %b want %b",
                         k + 1, out_valid, ev);
            else passed++;
            total++;
            if (out_data[k*32 +: 32] !== 32'hA0 + k)
                $display("FAIL skew_data_l%0d: got %h want %h",
                         k, out_data[k*32 +: 32], 32'hA0 + k);
            else passed++;
            total++;
            if (drained !== 1'b0)
                $display("FAIL skew_busy_e%0d: got %b want 0",
                         k + 1, drained);
            else passed++;
            if (k < 3) step();
        end
        step();
        total++;
        if (out_valid !== 4'b0 || drained !== 1'b1)
            $display("FAIL skew_drain: valid %b drained %b want 0000/1",
                     out_valid, drained);
        else passed++;
    endtask

    task automatic test_stall();
        // Word index expected on lane 2 after each edge 1..13; -1 = none.
        int exp_idx [13] = '{-1, -1, 0, 1, 1, 1, 2, 3, 4, 5, 6, 7, -1};
        for (int e = 1; e <= 13; e++) begin
            en = (e == 5 || e == 6) ? 1'b0 : 1'b1;
            in_valid = '0;
            in_data  = {4{32'hBAD0_0000}};
            if (e <= 4) begin
                in_valid[2] = 1'b1;
                in_data[64 +: 32] = 32'h100 + e - 1;
            end else if (e >= 7 && e <= 10) begin
                in_valid[2] = 1'b1;
                in_data[64 +: 32] = 32'h100 + e - 3;
            end
            step();
            total++;
            if (exp_idx[e-1] < 0) begin
                if (out_valid !== 4'b0)
                    $display("FAIL stall_idle_e%0d: got %b want 0000",
                             e, out_valid);
                else passed++;
            end else begin
                if (out_valid !== 4'b0100 ||
                    out_data[64 +: 32] !== 32'h100 + exp_idx[e-1])
                    $display("FAIL stall_e%0d: got %b/%h want 0100/%h",
                             e, out_valid, out_data[64 +: 32],
                             32'h100 + exp_idx[e-1]);
                else passed++;
            end
        end
        en = 1'b1;
        in_valid = '0;
        in_data  = '0;
        total++;
        if (drained !== 1'b1)
            $display("FAIL stall_drained: got %b want 1", drained);
        else passed++;
    endtask

    task automatic test_flush();
        for (int c = 0; c < 4; c++) begin
            in_valid = 4'hF;
            for (int i = 0; i < 4; i++)
                in_data[i*32 +: 32] = 32'hB0 + c;
            step();
        end
        total++;
        if (out_valid !== 4'hF || drained !== 1'b0)
            $display("FAIL flush_fill: valid %b drained %b want 1111/0",
                     out_valid, drained);
        else passed++;
        flush = 1'b1;
        in_valid = 4'hF;
        in_data  = {4{32'hDEAD_BEEF}};
        step();
        flush = 1'b0;
        in_valid = '0;
        in_data  = '0;
        total++;
        if (out_valid !== 4'b0 || drained !== 1'b1)
            $display("FAIL flush_clear: valid %b drained %b want 0000/1",
                     out_valid, drained);
        else passed++;
        for (int c = 0; c < 5; c++) begin
            step();
            total++;
            if (out_valid !== 4'b0)
                $display("FAIL flush_ghost_c%0d: got %b want 0000",
                         c, out_valid);
            else passed++;
        end
    endtask

    task automatic test_flush_stall();
        in_valid = 4'b0001;
        in_data  = {96'd0, 32'h5151_0000};
        step();
        en = 1'b0;
        flush = 1'b1;
        in_valid = 4'b0001;
        in_data  = {96'd0, 32'h7777_7777};
        step();
        total++;
        if (out_valid !== 4'b0 || out_data[31:0] !== 32'h5151_0000 ||
            drained !== 1'b1)
            $display("FAIL flush_hold: got %b/%h/%b want 0000/51510000/1",
                     out_valid, out_data[31:0], drained);
        else passed++;
        en = 1'b1;
        flush = 1'b0;
        in_valid = '0;
        in_data  = '0;
        for (int c = 0; c < 4; c++) step();
    endtask

    task automatic test_reset_mid();
        logic [3:0] ev;
        for (int c = 0; c < 2; c++) begin
            in_valid = 4'hF;
            in_data  = {4{32'hCAFE_0000 + c}};
            step();
        end
        rst = 1'b0;
        in_valid = 4'hF;
        step();
        rst = 1'b1;
        total++;
        if (out_valid !== 4'b0 || drained !== 1'b1 ||
            out_data !== 128'd0)
            $display("FAIL rstmid_clear: %b/%b/%h want 0000/1/0",
                     out_valid, drained, out_data);
        else passed++;
        for (int i = 0; i < 4; i++)
            in_data[i*32 +: 32] = 32'hC0 + i;
        in_valid = 4'hF;
        step();
        in_valid = '0;
        in_data  = '0;
        for (int k = 0; k < 4; k++) begin
            ev = 4'b0001 << k;
            total++;
            if (out_valid !== ev ||
                out_data[k*32 +: 32] !== 32'hC0 + k)
                $display("FAIL rstmid_e%0d: got %b/%h want %b/%h",
                         k + 1, out_valid, out_data[k*32 +: 32],
                         ev, 32'hC0 + k);
            else passed++;
            step();
        end
        total++;
        if (drained !== 1'b1)
            $display("FAIL rstmid_drained: got %b want 1", drained);
        else passed++;
    endtask

    task automatic test_sweep();
        logic [7:0] ev;
        logic       ok;
        in_valid1 = 1'b1;
        in_data1  = 32'h11;
        in_valid8 = 8'hFF;
        for (int i = 0; i < 8; i++)
            in_data8[i*32 +: 32] = 32'h80 + i;
        for (int e = 1; e <= 16; e++) begin
            step();
            in_valid1 = '0;
            in_data1  = '0;
            in_valid8 = '0;
            in_data8  = '0;
            if (e <= 4) begin
                total++;
                if (out_valid1 !== (e == 3) ||
                    (e == 3 && out_data1 !== 32'h11))
                    $display("FAIL sweep1_e%0d: got %b/%h want %b/11",
                             e, out_valid1, out_data1, (e == 3));
                else passed++;
            end
            ev = '0;
            for (int i = 0; i < 8; i++)
                ev[i] = (e == 1 + 2 * i);
            ok = (out_valid8 === ev);
            for (int i = 0; i < 8; i++)
                if (ev[i] && out_data8[i*32 +: 32] !== 32'h80 + i)
                    ok = 1'b0;
            total++;
            if (!ok)
                $display("FAIL sweep8_e%0d: got %b want %b",
                         e, out_valid8, ev);
            else passed++;
        end
        total++;
        if (drained1 !== 1'b1 || drained8 !== 1'b1)
            $display("FAIL sweep_drained: got %b/%b want 1/1",
                     drained1, drained8);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_skew();
        test_stall();
        test_flush();
        test_flush_stall();
        test_reset_mid();
        test_sweep();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/skew_delay_bank.md
# skew_delay_bank

Parametrised multi-lane delay bank that skews operand vectors into the systolic matrix-multiply array. Lane i delays its data and valid bit by BASE_DELAY + i*SKEW cycles, so row/column operands reach each processing element on the right wavefront. Adds a global stall (`en`), a synchronous valid `flush`, and a `drained` status, none of which the fixed two-stage delay cell provides. Sits between the operand source and the array edge, one instance per array side.

## Interface
- WIDTH, 32, data bits per lane
- LANES, 4, number of independent lanes (≥1)
- BASE_DELAY, 1, delay of lane 0 in cycles (≥1)
- SKEW, 1, extra delay per lane index (≥0)

- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  synchronous, active-low reset (sampled on clk rising edge)
- en  in  1  advance enable; 0 = every stage holds
- flush  in  1  clear all valid bits in the bank
- in_valid  in  LANES  per-lane input valid
- in_data  in  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
- out_valid  out  LANES  per-lane output valid, registered
- out_data  out  LANES*WIDTH  per-lane output data, registered, same packing
- drained  out  1  high when no valid bit is held in any stage of any lane

## Operation
- Lane i is a shift chain of D_i = BASE_DELAY + i*SKEW stages; each stage holds a WIDTH data word and a valid bit.
- en=1: every stage loads from its predecessor; stage 0 of lane i loads in_data/in_valid lane i. Data shifts regardless of valid.
- en=0: all stages hold; inputs in that cycle are dropped (the source must not present valid data while en=0).
- flush=1: all valid bits clear at the edge; data registers keep or shift per en; in_valid of that cycle is dropped. Flush overrides en for valid bits.
- rst=0: all data and valid registers go to 0 at the edge; rst overrides flush and en.
- out_valid/out_data are the last stage of each lane. out_data is defined only when the matching out_valid=1, except after reset, when it is 0.
- drained = NOR of all valid bits in all stages (combinational from registers). It is 1 after reset and after flush.

## Timing
- Reset values: out_valid=0, out_data=0, drained=1.
- Latency of lane i: D_i enabled cycles. A sample accepted at edge t (en=1) appears on lane i output after edge t+D_i−1, assuming en=1 throughout. Each en=0 cycle adds one cycle.
- Throughput: one word per lane per enabled cycle; no backpressure beyond en.
- Simultaneous en=0 and flush=1: valids clear, data holds.
- Reset mid-stream: all in-flight tokens are lost; the first post-reset accepted token sees full latency D_i.
- drained falls in the cycle after the first valid is captured. It rises in the cycle after the last valid leaves the final stage, or after a flush edge.

## Structure
- Shared package `systolic_pkg`: DATA_WIDTH default (32) and function `lane_depth(i, base, skew)` returning BASE_DELAY + i*SKEW; the array top uses the same function for wavefront alignment.
- One sub-module, `delay_line`: parameters WIDTH and DEPTH; ports clk, rst, en, flush, in_valid, in_data, out_valid, out_data, any_valid. Instantiated per lane in a generate loop with DEPTH = lane_depth(i, …).
- Top: a generate loop, plus drained = ~|any_valid.

## Test plan
- Reset: hold rst=0 with random inputs and en=1 for 3 cycles → out_valid=0, out_data=0, drained=1.
- Skew alignment (LANES=4, BASE=1, SKEW=1): pulse in_valid=4'b1111, data lane i = 32'hA0+i, for one cycle → lane i out_valid high exactly at edge i+1 after capture, with data A0+i; drained returns to 1 after lane 3 exits.
- Stall: stream 8 consecutive words on lane 2 and drop en for 2 cycles mid-stream → outputs freeze for 2 cycles; order intact; no loss or duplication; total latency = 3 + 2.
- Flush: fill all lanes with valid data, then assert flush for 1 cycle with in_valid=1 → next cycle all out_valid=0 and drained=1; the flush-cycle input never appears.
- Reset mid-stream: assert rst=0 for 1 cycle while lanes are half full → all valids cleared; a word sent afterwards arrives with full D_i latency.
- Parameter sweep: LANES=1, BASE=3, SKEW=0 and LANES=8, SKEW=2 → lane latencies match lane_depth for every lane.
